// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame geometry and parity helper.
// Pure declarations; no timing and no flow control of its own.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_REL,
    ST_BIT_HI,
    ST_BIT_LO,
    ST_GAP
  } ps2_state_e;

  localparam int FRAME_BITS       = 11;
  localparam int LAST_BIT         = 10;
  localparam int INHIBIT_MASK_CYC = 3;

  // Odd parity: the bit that makes the total count of ones in data+parity odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~(^b);
  endfunction

endpackage

// File: rtl/ps2_device_tx_if.sv
// Byte-request / status bundle plus the PS/2 line pins between a client and ps2_device_tx.
// master = client driving bytes and the sensed clock line; slave = the transmitter.
interface ps2_device_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       ps2c_in;
  logic       ps2c_o;
  logic       ps2d_o;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_abort;

  modport master (
    output tx_data, tx_start, ps2c_in,
    input  ps2c_o, ps2d_o, tx_busy, tx_done, tx_abort
  );

  modport slave (
    input  tx_data, tx_start, ps2c_in,
    output ps2c_o, ps2d_o, tx_busy, tx_done, tx_abort
  );
endinterface

// File: rtl/ps2_sync.sv
// Two-flop synchroniser for an asynchronous PS/2 line, reset to the released (high) level.
// Latency 2 clk cycles; no backpressure.
module ps2_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic [1:0] r_ff;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ff <= 2'b11;
    end else begin
      r_ff <= {r_ff[0], i_async};
    end
  end

  assign o_sync = r_ff[1];

endmodule

// File: rtl/ps2_device_tx.sv
// PS/2 device-side frame transmitter; first data bit on the line 1 cycle after an accepted start, tx_start ignored while busy.
// Host inhibit aborts the frame; with PS2_TX_RETRY_EN defined the frame is retried after the inhibit releases.
module ps2_device_tx
  import ps2_pkg::*;
#(
  parameter int HALF_CYC = 4000,
  parameter int IDLE_GAP = 8000,
  parameter int CNT_W    = 16
) (
  input logic            clk,
  input logic            reset,
  ps2_device_tx_if.slave bus
);

  ps2_state_e            r_state;
  ps2_state_e            w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [3:0]            r_idx;
  logic [FRAME_BITS-1:0] r_frame;
  logic                  r_done;
  logic                  r_abort;
`ifndef PS2_TX_RETRY_EN
  logic                  r_aborted;
`endif

  logic w_ps2c_s;
  logic w_half_end;
  logic w_gap_end;
  logic w_inhibit;

  ps2_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (bus.ps2c_in),
    .o_sync  (w_ps2c_s)
  );

  assign w_half_end = (r_cnt == CNT_W'(HALF_CYC - 1));
  assign w_gap_end  = (r_cnt == CNT_W'(IDLE_GAP - 1));
  // The first cycles of BIT_HI still see our own low clock through the synchroniser.
  assign w_inhibit  = !w_ps2c_s && (r_cnt >= CNT_W'(INHIBIT_MASK_CYC)) &&
                      (r_idx <= 4'(LAST_BIT - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_frame   <= '0;
      r_done    <= 1'b0;
      r_abort   <= 1'b0;
`ifndef PS2_TX_RETRY_EN
      r_aborted <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == ST_GAP) && (w_next == ST_IDLE);
      r_abort <= (r_state == ST_BIT_HI) && w_inhibit;

      // WAIT_REL counts consecutive released cycles; other states count time in state.
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else if ((r_state == ST_WAIT_REL) && !w_ps2c_s) begin
        r_cnt <= '0;
      end else if (r_state != ST_IDLE) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (bus.tx_start) begin
            r_frame   <= {1'b1, odd_parity(bus.tx_data), bus.tx_data, 1'b0};
            r_idx     <= '0;
`ifndef PS2_TX_RETRY_EN
            r_aborted <= 1'b0;
`endif
          end
        end
        ST_WAIT_REL: begin
          if (w_next != ST_WAIT_REL) begin
            r_idx     <= '0;
`ifndef PS2_TX_RETRY_EN
            r_aborted <= 1'b0;
`endif
          end
        end
`ifndef PS2_TX_RETRY_EN
        ST_BIT_HI: begin
          if (w_inhibit) begin
            r_aborted <= 1'b1;
            r_frame   <= '1;
          end
        end
`endif
        ST_BIT_LO: begin
          if (w_next == ST_BIT_HI) begin
            r_idx <= r_idx + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.tx_start) begin
          w_next = w_ps2c_s ? ST_BIT_HI : ST_WAIT_REL;
        end
      end
      ST_WAIT_REL: begin
        if (w_ps2c_s && w_gap_end) begin
`ifdef PS2_TX_RETRY_EN
          w_next = ST_BIT_HI;
`else
          w_next = r_aborted ? ST_IDLE : ST_BIT_HI;
`endif
        end
      end
      ST_BIT_HI: begin
        if (w_inhibit) begin
          w_next = ST_WAIT_REL;
        end else if (w_half_end) begin
          w_next = ST_BIT_LO;
        end
      end
      ST_BIT_LO: begin
        if (w_half_end) begin
          w_next = (r_idx == 4'(LAST_BIT)) ? ST_GAP : ST_BIT_HI;
        end
      end
      ST_GAP: begin
        if (w_gap_end) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.ps2c_o   = 1'b1;
    bus.ps2d_o   = 1'b1;
    bus.tx_busy  = (r_state != ST_IDLE);
    bus.tx_done  = r_done;
    bus.tx_abort = r_abort;
    case (r_state)
      ST_BIT_HI: bus.ps2d_o = r_frame[r_idx];
      ST_BIT_LO: begin
        bus.ps2c_o = 1'b0;
        bus.ps2d_o = r_frame[r_idx];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Randomised frame checks for ps2_device_tx against a frame-level reference model.
module tb_ps2_device_tx;

  localparam int H         = 4;
  localparam int G         = 8;
  localparam int FRAME_LAT = 22 * H + G + 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ps2_device_tx_if bus ();

  ps2_device_tx #(
    .HALF_CYC (H),
    .IDLE_GAP (G),
    .CNT_W    (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: start 0, D0..D7, odd parity, stop 1 (index = bit order on the wire).
  function automatic logic [10:0] ref_frame(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = ($countones(b) % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // Line monitor: data captured at each falling ps2c_o edge, plus done/abort events.
  logic bits_q[$];
  int   done_cnt     = 0;
  int   abort_cnt    = 0;
  int   done_cyc     = 0;
  logic busy_at_done = 1'b1;
  logic prev_c       = 1'b1;
  logic prev_d       = 1'b1;
  int   stab         = 0;

  always @(negedge clk) begin
    if (bus.ps2d_o !== prev_d) stab = 0;
    else stab++;
    if (prev_c === 1'b1 && bus.ps2c_o === 1'b0) begin
      bits_q.push_back(bus.ps2d_o);
      check("data_setup", 32'(stab >= H), 1);
    end
    if (bus.tx_done === 1'b1) begin
      done_cnt++;
      done_cyc     = cyc;
      busy_at_done = bus.tx_busy;
    end
    if (bus.tx_abort === 1'b1) abort_cnt++;
    prev_c = bus.ps2c_o;
    prev_d = bus.ps2d_o;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] b, output int s);
    bus.tx_data  = b;
    bus.tx_start = 1'b1;
    s = cyc;
    tick();
    bus.tx_start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string tag);
    for (int i = 0; i < 400 && done_cnt == d0; i++) tick();
    check({tag, "_done_seen"}, 32'(done_cnt != d0), 1);
  endtask

  task automatic wait_bits(input int n, input string tag);
    for (int i = 0; i < 400 && bits_q.size() < n; i++) tick();
    check({tag, "_bits_reached"}, 32'(bits_q.size() >= n), 1);
  endtask

  task automatic wait_clk_high(input string tag);
    for (int i = 0; i < 40 && bus.ps2c_o !== 1'b1; i++) tick();
    check({tag, "_clk_high"}, 32'(bus.ps2c_o), 1);
  endtask

  task automatic check_frame(input logic [7:0] b, input string tag);
    logic [10:0] f;
    f = ref_frame(b);
    check({tag, "_nbits"}, bits_q.size(), 11);
    for (int k = 0; k < 11 && k < bits_q.size(); k++)
      check($sformatf("%s_bit%0d", tag, k), 32'(bits_q[k]), 32'(f[k]));
  endtask

  task automatic send_and_check(input logic [7:0] b, input string tag);
    int s;
    int d0;
    int a0;
    bits_q.delete();
    d0 = done_cnt;
    a0 = abort_cnt;
    pulse_start(b, s);
    check({tag, "_busy_next"}, 32'(bus.tx_busy), 1);
    wait_done(d0, tag);
    check({tag, "_latency"}, done_cyc - s, FRAME_LAT);
    check({tag, "_busy_at_done"}, 32'(busy_at_done), 0);
    check({tag, "_done_once"}, done_cnt, d0 + 1);
    check({tag, "_no_abort"}, abort_cnt, a0);
    check_frame(b, tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          s;
    int          s2;
    int          d0;
    int          a0;
    int          r_cyc;
    int          first_low;
    logic [7:0]  b;
    logic [10:0] v;

    bus.tx_data  = 8'h00;
    bus.tx_start = 1'b0;
    bus.ps2c_in  = 1'b1;
    reset        = 1'b0;
    repeat (3) tick();
    check("rst_ps2c", 32'(bus.ps2c_o), 1);
    check("rst_ps2d", 32'(bus.ps2d_o), 1);
    check("rst_busy", 32'(bus.tx_busy), 0);
    check("rst_done", 32'(bus.tx_done), 0);
    check("rst_abort", 32'(bus.tx_abort), 0);
    reset = 1'b1;
    repeat (3) tick();

    // Known vector from the datasheet example.
    send_and_check(8'h1C, "b1c");
    for (int k = 0; k < 11; k++) v[k] = (k < bits_q.size()) ? bits_q[k] : 1'bx;
    v = v;
    check("b1c_pattern", 32'(v), 32'h438);

    send_and_check(8'h00, "b00");
    check("b00_parity", 32'(bits_q.size() > 9 ? bits_q[9] : 1'bx), 1);
    send_and_check(8'hFF, "bff");
    check("bff_parity", 32'(bits_q.size() > 9 ? bits_q[9] : 1'bx), 1);
    send_and_check(8'h01, "b01");
    check("b01_parity", 32'(bits_q.size() > 9 ? bits_q[9] : 1'bx), 0);

    for (int n = 0; n < 6; n++) begin
      b = 8'($urandom);
      repeat ($urandom_range(0, 5)) tick();
      send_and_check(b, $sformatf("rnd%0d", n));
    end

    // Second start while busy must be dropped.
    bits_q.delete();
    d0 = done_cnt;
    pulse_start(8'hA5, s);
    repeat (3) tick();
    pulse_start(8'h3C, s2);
    wait_done(d0, "busy_ign");
    check("busy_ign_latency", done_cyc - s, FRAME_LAT);
    check_frame(8'hA5, "busy_ign");
    repeat (40) tick();
    check("busy_ign_one_done", done_cnt, d0 + 1);
    check("busy_ign_no_extra_bits", bits_q.size(), 11);

    // Host inhibit during bit 4.
    bits_q.delete();
    d0 = done_cnt;
    a0 = abort_cnt;
    pulse_start(8'h96, s);
    wait_bits(4, "abort");
    wait_clk_high("abort");
    bus.ps2c_in = 1'b0;
    for (int i = 0; i < 20 && abort_cnt == a0; i++) tick();
    check("abort_seen", abort_cnt, a0 + 1);
    check("abort_ps2c_high", 32'(bus.ps2c_o), 1);
    check("abort_ps2d_high", 32'(bus.ps2d_o), 1);
    check("abort_nbits", bits_q.size(), 4);
    bits_q.delete();
    repeat (4) tick();
    bus.ps2c_in = 1'b1;
    r_cyc = cyc;
`ifdef PS2_TX_RETRY_EN
    begin
      logic dropped;
      dropped   = 1'b0;
      first_low = -1;
      for (int i = 0; i < 400 && done_cnt == d0; i++) begin
        tick();
        if (first_low < 0 && bus.ps2d_o === 1'b0) first_low = cyc;
        if (done_cnt == d0 && bus.tx_busy !== 1'b1) dropped = 1'b1;
      end
      check("retry_done_seen", 32'(done_cnt != d0), 1);
      check("retry_busy_held", 32'(dropped), 0);
      check("retry_restart_delay", first_low - r_cyc, G + 2);
      check_frame(8'h96, "retry");
    end
`else
    for (int i = 0; i < 40 && bus.tx_busy !== 1'b0; i++) tick();
    check("abort_busy_clears", 32'(bus.tx_busy), 0);
    repeat (30) tick();
    check("abort_no_done", done_cnt, d0);
    check("abort_no_resend", bits_q.size(), 0);
`endif
    check("abort_single_pulse", abort_cnt, a0 + 1);
    repeat (3) tick();

    // Inhibit during the stop bit is ignored.
    bits_q.delete();
    d0 = done_cnt;
    a0 = abort_cnt;
    pulse_start(8'h5A, s);
    wait_bits(10, "stop_inh");
    wait_clk_high("stop_inh");
    bus.ps2c_in = 1'b0;
    repeat (H + 3) tick();
    bus.ps2c_in = 1'b1;
    wait_done(d0, "stop_inh");
    check("stop_inh_latency", done_cyc - s, FRAME_LAT);
    check("stop_inh_no_abort", abort_cnt, a0);
    check_frame(8'h5A, "stop_inh");
    repeat (3) tick();

    // Line inhibited when the start arrives; frame begins after the release window.
    bus.ps2c_in = 1'b0;
    repeat (3) tick();
    bits_q.delete();
    d0 = done_cnt;
    pulse_start(8'hE7, s);
    check("inh_start_busy", 32'(bus.tx_busy), 1);
    repeat (19) tick();
    check("inh_start_data_held", 32'(bus.ps2d_o), 1);
    bus.ps2c_in = 1'b1;
    r_cyc       = cyc;
    first_low   = -1;
    for (int i = 0; i < 40 && first_low < 0; i++) begin
      tick();
      if (bus.ps2d_o === 1'b0) first_low = cyc;
    end
    check("inh_start_delay", first_low - r_cyc, G + 2);
    wait_done(d0, "inh_start");
    check_frame(8'hE7, "inh_start");
    repeat (3) tick();

    // Reset in the low half of bit 6.
    bits_q.delete();
    d0 = done_cnt;
    pulse_start(8'h9A, s);
    wait_bits(7, "mid_rst");
    check("mid_rst_pre_ps2d", 32'(bus.ps2d_o), 0);
    reset = 1'b0;
    tick();
    check("mid_rst_ps2c", 32'(bus.ps2c_o), 1);
    check("mid_rst_ps2d", 32'(bus.ps2d_o), 1);
    check("mid_rst_busy", 32'(bus.tx_busy), 0);
    reset = 1'b1;
    repeat (30) tick();
    check("mid_rst_no_done", done_cnt, d0);
    send_and_check(8'h9A, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_device_tx.md
Name: ps2_device_tx

Overview:
PS/2 device-side transmitter that emulates a keyboard and drives frames onto the ps2c/ps2d lines consumed by the PicoBlaze PS/2 receiver. A byte presented with a start strobe is serialised as a standard 11-bit PS/2 frame with a device-generated clock. The block serves as a synthesizable loopback source on the board and as a stimulus generator in the system testbench. It also honours host inhibit, meaning the host holds the clock low.

Parameters:
HALF_CYC, 4000, clk cycles per PS/2 clock half-period (100 MHz / (2 × 12.5 kHz)).
IDLE_GAP, 8000, clk cycles of line-idle after a stop bit, and the required inhibit-release time.
CNT_W, 16, width of the cycle counter; must hold max(HALF_CYC, IDLE_GAP).

Ports:
clk  input  1  system clock, 100 MHz.
reset  input  1  synchronous, active-low reset.
tx_data  input  8  byte to send; captured on accepted tx_start.
tx_start  input  1  one-cycle request; accepted only when tx_busy=0.
ps2c_in  input  1  sensed PS/2 clock line, asynchronous, for inhibit detection.
ps2c_o  output  1  driven PS/2 clock; 1 = released/high.
ps2d_o  output  1  driven PS/2 data; 1 = released/high.
tx_busy  output  1  high from the cycle after acceptance until return to IDLE.
tx_done  output  1  one-cycle pulse when a frame plus IDLE_GAP completes.
tx_abort  output  1  one-cycle pulse when host inhibit kills a frame.

Behaviour:
- Reset (reset=0 at a clk edge):
  - ps2c_o=1, ps2d_o=1, tx_busy=0, tx_done=0, tx_abort=0.
  - State IDLE; counters and shift register cleared. Takes effect even mid-frame.
- Frame format: start bit 0, then D0..D7 LSB first, then odd parity (XOR of data, inverted), then stop bit 1. Total 11 bits; bit index 0..10.
- Inhibit sense: ps2c_in passes through a 2-FF synchroniser to give ps2c_s. Latency is 2 cycles.
- States: IDLE, WAIT_REL, BIT_HI, BIT_LO, GAP.
  - IDLE:
    - tx_start=1 latches {1, parity, tx_data, 0} into an 11-bit shift register.
    - Next state is BIT_HI if ps2c_s=1, otherwise WAIT_REL. tx_busy=1 from the next cycle.
  - WAIT_REL: outputs held high. Leave only after ps2c_s=1 for IDLE_GAP consecutive cycles, then go to BIT_HI.
  - BIT_HI:
    - On entry, ps2d_o takes the current bit and ps2c_o=1.
    - After HALF_CYC cycles, go to BIT_LO.
    - Inhibit check: if ps2c_s=0 while the in-state count is ≥3 (masks synchroniser latency) and bit index ≤9, then abort.
  - BIT_LO:
    - ps2c_o=0 for HALF_CYC cycles, then ps2c_o=1.
    - Index <10: shift and go to BIT_HI.
    - Index =10: go to GAP.
    - The host samples ps2d on the falling edge; data is stable for HALF_CYC cycles beforehand.
  - GAP: ps2c_o=ps2d_o=1 for IDLE_GAP cycles. Then tx_done pulses for 1 cycle, with tx_busy=0 in that same cycle, and the state returns to IDLE.
  - Abort: ps2c_o=ps2d_o=1, tx_abort pulses for 1 cycle, state goes to WAIT_REL, and the frame is discarded. Leaving WAIT_REL after an abort goes to IDLE with tx_busy=0; no tx_done is issued.
- Latency: tx_start at edge N gives ps2d_o=0 at N+1 (line free). The first ps2c_o fall is at N+1+HALF_CYC. A full frame takes 22·HALF_CYC+IDLE_GAP+1 cycles to tx_done.
- tx_start while busy is ignored; there is no queue.
- Inhibit at bit index 10 (stop bit) is ignored; the frame completes.

Optional Feature:
PS2_TX_RETRY_EN
- Defined: on abort, the shift register is kept. After WAIT_REL the frame restarts from the start bit, and tx_busy stays high throughout. Retries are unlimited.
- Undefined: abort discards the frame as described above.
- tx_abort pulses in both cases.

Decomposition:
- ps2_pkg:
  - State enum.
  - FRAME_BITS=11, LAST_BIT=10, INHIBIT_MASK_CYC=3.
  - odd_parity(byte) function.
- Sub-module ps2_sync: 2-FF synchroniser with reset to 1, reusable by the receiver.

Test Plan:
All scenarios use HALF_CYC=4 and IDLE_GAP=8.
- Send 0x1C with ps2c_in=1 → ps2d_o sampled at 11 ps2c_o falls reads 0,0,0,1,1,1,0,0,0,0,1 (D0..D7=00111000, parity 0). tx_done arrives 97 cycles after tx_start.
- Send 0x00 → parity bit 1. Send 0xFF → parity bit 1. Send 0x01 → parity bit 0.
- tx_start pulsed at cycles 1 and 5 while busy → exactly one frame and one tx_done.
- Force ps2c_in=0 in BIT_HI of bit 4 → tx_abort pulses, outputs go high, no tx_done. With PS2_TX_RETRY_EN, the frame fully resends after 8 idle-high cycles.
- ps2c_in=0 at tx_start, released 20 cycles later → first ps2d_o=0 appears 8 cycles after release plus synchroniser latency.
- reset=0 during bit 6 → next cycle ps2c_o=ps2d_o=1 and tx_busy=0. A new tx_start after release sends a clean frame.
